// File: rtl/srm_cpu.sv
// srm_cpu: multicycle Simple RISC Machine core with on-chip PC, load/store and HALT.
// Instructions and data share one synchronous-read memory port with one cycle of read latency.
module srm_cpu #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] out,
    output logic              N,
    output logic              V,
    output logic              Z,
    output logic              halted
);

    typedef enum logic [3:0] {
        StRst,
        StFetch,
        StFwait,
        StDecode,
        StGetA,
        StGetB,
        StAlu,
        StWb,
        StAddr,
        StMemRd,
        StMemWait,
        StGetD,
        StMemWr,
        StHalt
    } state_e;

    localparam logic [2:0] OpcMov = 3'b110;
    localparam logic [2:0] OpcAlu = 3'b101;
    localparam logic [2:0] OpcLdr = 3'b011;
    localparam logic [2:0] OpcStr = 3'b100;

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluCmp = 2'b01;
    localparam logic [1:0] AluAnd = 2'b10;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       ir_q;
    logic [DATA_W-1:0] a_q, b_q, c_q;
    logic [DATA_W-1:0] regs_q [8];
    logic              n_q, v_q, z_q;

    logic [2:0]        opcode;
    logic [1:0]        op;
    logic [2:0]        rn, rd, rm;
    logic [1:0]        sh;
    logic [DATA_W-1:0] sximm8, sximm5;
    logic              is_mov_imm, is_mov_reg, is_alu, is_ldr, is_str, is_cmp;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];
    assign sximm8 = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
    assign sximm5 = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};

    assign is_mov_imm = (opcode == OpcMov) && (op == 2'b10);
    assign is_mov_reg = (opcode == OpcMov) && (op == 2'b00);
    assign is_alu     = (opcode == OpcAlu);
    assign is_cmp     = is_alu && (op == AluCmp);
    assign is_ldr     = (opcode == OpcLdr) && (op == 2'b00);
    assign is_str     = (opcode == OpcStr) && (op == 2'b00);

    // Shifter feeds only the B (Rm) operand
    logic [DATA_W-1:0] b_sh, diff, alu_res;

    always_comb begin
        case (sh)
            2'b00:   b_sh = b_q;
            2'b01:   b_sh = {b_q[DATA_W-2:0], 1'b0};
            2'b10:   b_sh = {1'b0, b_q[DATA_W-1:1]};
            default: b_sh = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
        endcase
    end

    assign diff = a_q - b_sh;

    always_comb begin
        alu_res = b_sh;
        if (!is_mov_reg) begin
            case (op)
                AluAdd:  alu_res = a_q + b_sh;
                AluCmp:  alu_res = diff;
                AluAnd:  alu_res = a_q & b_sh;
                default: alu_res = ~b_sh;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StRst;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = b_q;
        case (state_q)
            StRst:    state_d = StFetch;
            StFetch: begin
                mem_rd  = 1'b1;
                state_d = StFwait;
            end
            StFwait:  state_d = StDecode;
            StDecode: begin
                if (is_mov_imm) begin
                    state_d = StWb;
                end else if (is_mov_reg || (is_alu && op == 2'b11)) begin
                    state_d = StGetB;
                end else if (is_alu || is_ldr || is_str) begin
                    state_d = StGetA;
                end else begin
                    state_d = StHalt;
                end
            end
            StGetA:   state_d = (is_ldr || is_str) ? StAddr : StGetB;
            StGetB:   state_d = StAlu;
            StAlu:    state_d = is_cmp ? StFetch : StWb;
            StWb:     state_d = StFetch;
            StAddr:   state_d = is_ldr ? StMemRd : StGetD;
            StMemRd: begin
                mem_rd   = 1'b1;
                mem_addr = c_q[ADDR_W-1:0];
                state_d  = StMemWait;
            end
            StMemWait: state_d = StFetch;
            StGetD:    state_d = StMemWr;
            StMemWr: begin
                mem_wr   = 1'b1;
                mem_addr = c_q[ADDR_W-1:0];
                state_d  = StFetch;
            end
            StHalt:    state_d = StHalt;
            default:   state_d = StRst;
        endcase
        // An interrupted access must never reach memory
        if (!reset) begin
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= ADDR_W'(RESET_PC);
            ir_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            n_q  <= 1'b0;
            v_q  <= 1'b0;
            z_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StFwait: begin
                    ir_q <= mem_rdata[15:0];
                    pc_q <= pc_q + ADDR_W'(1);
                end
                StGetA: a_q <= regs_q[rn];
                StGetB: b_q <= regs_q[rm];
                StAlu: begin
                    if (is_cmp) begin
                        n_q <= diff[DATA_W-1];
                        z_q <= (diff == '0);
                        v_q <= (a_q[DATA_W-1] ^ b_sh[DATA_W-1]) & (diff[DATA_W-1] ^ a_q[DATA_W-1]);
                    end else begin
                        c_q <= alu_res;
                    end
                end
                StWb: begin
                    if (is_mov_imm) begin
                        regs_q[rn] <= sximm8;
                    end else begin
                        regs_q[rd] <= c_q;
                    end
                end
                StAddr:    c_q <= a_q + sximm5;
                StMemWait: regs_q[rd] <= mem_rdata;
                StGetD:    b_q <= regs_q[rd];
                default: ;
            endcase
        end
    end

    assign out    = c_q;
    assign N      = n_q;
    assign V      = v_q;
    assign Z      = z_q;
    assign halted = (state_q == StHalt) && reset;

endmodule

// File: tb/tb_srm_cpu.sv
// Directed self-checking bench for srm_cpu: default core plus a 32-bit/4-bit-address core
// whose reset PC sits at the top of memory.
module tb_srm_cpu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset0 = 1'b0;
    logic [15:0] mem_rdata0, mem_wdata0, out0;
    logic [8:0]  mem_addr0;
    logic        mem_rd0, mem_wr0, n0, v0, z0, halted0;

    logic        reset1 = 1'b0;
    logic [31:0] mem_rdata1, mem_wdata1, out1;
    logic [3:0]  mem_addr1;
    logic        mem_rd1, mem_wr1, n1, v1, z1, halted1;

    srm_cpu dut0 (
        .clk(clk), .reset(reset0), .mem_rdata(mem_rdata0), .mem_addr(mem_addr0),
        .mem_rd(mem_rd0), .mem_wr(mem_wr0), .mem_wdata(mem_wdata0), .out(out0),
        .N(n0), .V(v0), .Z(z0), .halted(halted0)
    );

    srm_cpu #(.DATA_W(32), .ADDR_W(4), .RESET_PC(15)) dut1 (
        .clk(clk), .reset(reset1), .mem_rdata(mem_rdata1), .mem_addr(mem_addr1),
        .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_wdata(mem_wdata1), .out(out1),
        .N(n1), .V(v1), .Z(z1), .halted(halted1)
    );

    // Synchronous-read memories with a bench-side load port used while the core is in reset
    logic [15:0] ram0 [512];
    logic [31:0] ram1 [16];
    logic        tb_we0 = 1'b0, tb_we1 = 1'b0;
    logic [8:0]  tb_a = '0;
    logic [31:0] tb_d = '0;

    always_ff @(posedge clk) begin
        if (tb_we0) ram0[tb_a] <= tb_d[15:0];
        else if (mem_wr0) ram0[mem_addr0] <= mem_wdata0;
        mem_rdata0 <= ram0[mem_addr0];
    end

    always_ff @(posedge clk) begin
        if (tb_we1) ram1[tb_a[3:0]] <= tb_d;
        else if (mem_wr1) ram1[mem_addr1] <= mem_wdata1;
        mem_rdata1 <= ram1[mem_addr1];
    end

    int passed = 0, total = 0, fails = 0;
    int cyc;
    int wr_n;
    logic [8:0]  wr_a;
    logic [15:0] wr_d;
    logic [15:0] prog [$];

    localparam logic [15:0] HLT = 16'hE000;

    function automatic logic [15:0] e_movi(input logic [2:0] rn, input logic [7:0] imm);
        return {3'b110, 2'b10, rn, imm};
    endfunction
    function automatic logic [15:0] e_movr(input logic [2:0] rd, input logic [1:0] sh,
                                           input logic [2:0] rm);
        return {3'b110, 2'b00, 3'b000, rd, sh, rm};
    endfunction
    function automatic logic [15:0] e_alu(input logic [1:0] op, input logic [2:0] rn,
                                          input logic [2:0] rd, input logic [1:0] sh,
                                          input logic [2:0] rm);
        return {3'b101, op, rn, rd, sh, rm};
    endfunction
    function automatic logic [15:0] e_ldr(input logic [2:0] rd, input logic [2:0] rn,
                                          input logic [4:0] imm);
        return {3'b011, 2'b00, rn, rd, imm};
    endfunction
    function automatic logic [15:0] e_str(input logic [2:0] rd, input logic [2:0] rn,
                                          input logic [4:0] imm);
        return {3'b100, 2'b00, rn, rd, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr0(input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_a = a; tb_d = d; tb_we0 = 1'b1;
        @(posedge clk);
        #1 tb_we0 = 1'b0;
    endtask

    task automatic wr1(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_a = {5'b0, a}; tb_d = d; tb_we1 = 1'b1;
        @(posedge clk);
        #1 tb_we1 = 1'b0;
    endtask

    task automatic load0();
        for (int i = 0; i < prog.size(); i++) wr0(9'(i), {16'h0, prog[i]});
    endtask

    task automatic stop0();
        @(negedge clk); reset0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic start0();
        @(negedge clk); reset0 = 1'b1;
        cyc = 1; wr_n = 0;
    endtask

    task automatic step0();
        @(negedge clk);
        cyc++;
        if (mem_wr0) begin
            wr_n++; wr_a = mem_addr0; wr_d = mem_wdata0;
        end
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step0();
    endtask

    task automatic run0(input string tag, input int max);
        while (!halted0 && cyc < max) step0();
        chk(tag, 32'(halted0), 1);
    endtask

    task automatic run1(input string tag, input int max);
        cyc = 1;
        while (!halted1 && cyc < max) begin
            @(negedge clk); cyc++;
        end
        chk(tag, 32'(halted1), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst out", 32'(out0), 0);
        chk("rst flags", 32'({n0, v0, z0}), 0);
        chk("rst halted", 32'(halted0), 0);
        chk("rst strobes", 32'({mem_rd0, mem_wr0}), 0);
        chk("rst pc1", 32'(mem_addr1), 15);

        // MOV, MOV, ADD, HALT with exact cycle positions
        prog = {e_movi(3'd0, 8'd5), e_movi(3'd1, 8'hFD), e_alu(2'b00, 3'd0, 3'd2, 2'b00, 3'd1), HLT};
        load0();
        start0();
        chk("c1 rst no fetch", 32'(mem_rd0), 0);
        step0();
        chk("c2 fetch", 32'({mem_rd0, mem_addr0}), 32'({1'b1, 9'd0}));
        step_to(17);
        chk("c17 fetch halt", 32'({mem_rd0, mem_addr0}), 32'({1'b1, 9'd3}));
        step_to(19);
        chk("c19 not halted", 32'(halted0), 0);
        step_to(21);
        chk("c21 halted", 32'(halted0), 1);
        chk("add out", 32'(out0), 2);
        chk("halt pc", 32'(mem_addr0), 4);
        chk("add flags", 32'({n0, v0, z0}), 0);
        stop0();

        // CMP 3-5
        prog = {e_movi(3'd0, 8'd3), e_movi(3'd1, 8'd5), e_alu(2'b01, 3'd0, 3'd0, 2'b00, 3'd1), HLT};
        load0(); start0(); run0("cmp1 halt", 100);
        chk("cmp1 NVZ", 32'({n0, v0, z0}), 32'b100);
        chk("cmp1 out kept", 32'(out0), 0);
        stop0();

        // CMP R1,R1
        prog = {e_movi(3'd1, 8'd5), e_alu(2'b01, 3'd1, 3'd0, 2'b00, 3'd1), HLT};
        load0(); start0(); run0("cmp2 halt", 100);
        chk("cmp2 NVZ", 32'({n0, v0, z0}), 32'b001);
        stop0();

        // 0x7FFF vs -1 overflows; following ADD leaves flags alone
        prog = {e_movi(3'd0, 8'hFF), e_movr(3'd0, 2'b10, 3'd0), e_movi(3'd1, 8'hFF),
                e_alu(2'b01, 3'd0, 3'd0, 2'b00, 3'd1), e_alu(2'b00, 3'd0, 3'd2, 2'b00, 3'd1), HLT};
        load0(); start0(); run0("cmp3 halt", 100);
        chk("cmp3 NVZ held", 32'({n0, v0, z0}), 32'b110);
        chk("cmp3 add out", 32'(out0), 32'h7FFE);
        stop0();
        chk("reset clears flags", 32'({n0, v0, z0}), 0);
        chk("reset clears halted", 32'(halted0), 0);
        chk("reset clears out", 32'(out0), 0);

        // Shifts and MVN, stored to 32..35
        prog = {e_movi(3'd0, 8'd32), e_movi(3'd1, 8'hF8),
                e_movr(3'd2, 2'b10, 3'd1), e_str(3'd2, 3'd0, 5'd0),
                e_movr(3'd2, 2'b11, 3'd1), e_str(3'd2, 3'd0, 5'd1),
                e_movr(3'd2, 2'b01, 3'd1), e_str(3'd2, 3'd0, 5'd2),
                e_alu(2'b11, 3'd0, 3'd3, 2'b00, 3'd1), e_str(3'd3, 3'd0, 5'd3), HLT};
        load0(); start0(); run0("shift halt", 300);
        chk("lsr", 32'(ram0[32]), 32'h7FFC);
        chk("asr", 32'(ram0[33]), 32'hFFFC);
        chk("lsl", 32'(ram0[34]), 32'hFFF0);
        chk("mvn", 32'(ram0[35]), 32'h0007);
        chk("shift writes", 32'(wr_n), 4);
        chk("str out addr", 32'(out0), 35);
        stop0();

        // STR then LDR at R0-2
        wr0(9'd8, 32'h0);
        prog = {e_movi(3'd0, 8'd10), e_movi(3'd1, 8'h55), e_str(3'd1, 3'd0, 5'h1E),
                e_ldr(3'd2, 3'd0, 5'h1E), e_movr(3'd4, 2'b00, 3'd2), HLT};
        load0(); start0(); run0("ldst halt", 200);
        chk("str one cycle", 32'(wr_n), 1);
        chk("str addr", 32'(wr_a), 8);
        chk("str data", 32'(wr_d), 32'h55);
        chk("ram8", 32'(ram0[8]), 32'h55);
        chk("ldr out", 32'(out0), 32'h55);
        stop0();

        // Reset dropped during MEMWR
        wr0(9'd8, 32'hAAAA);
        prog = {e_movi(3'd0, 8'd10), e_movi(3'd1, 8'h55), e_str(3'd1, 3'd0, 5'h1E), HLT};
        load0(); start0();
        while (!mem_wr0 && cyc < 60) step0();
        chk("memwr reached", 32'(mem_wr0), 1);
        reset0 = 1'b0;
        #1;
        chk("memwr killed", 32'({mem_rd0, mem_wr0}), 0);
        @(negedge clk);
        reset0 = 1'b1;
        chk("rst cycle idle", 32'(mem_rd0), 0);
        @(negedge clk);
        chk("refetch", 32'({mem_rd0, mem_addr0}), 32'({1'b1, 9'd0}));
        chk("store dropped", 32'(ram0[8]), 32'hAAAA);
        stop0();

        // Wide core: MOV at 15, HALT at 0 after wrap
        wr1(4'd15, {16'h0, e_movi(3'd0, 8'h80)});
        wr1(4'd0, {16'h0, HLT});
        @(negedge clk); reset1 = 1'b1;
        chk("w rst pc", 32'({mem_rd1, mem_addr1}), 32'({1'b0, 4'd15}));
        run1("w halt", 40);
        chk("w halt pc", 32'(mem_addr1), 1);
        @(negedge clk); reset1 = 1'b0;
        @(negedge clk);

        // Expose the sign-extended immediate through MOV reg
        wr1(4'd0, {16'h0, e_movr(3'd1, 2'b00, 3'd0)});
        wr1(4'd1, {16'h0, HLT});
        @(negedge clk); reset1 = 1'b1;
        run1("w2 halt", 40);
        chk("w sximm8", out1, 32'hFFFF_FF80);
        chk("w2 halt pc", 32'(mem_addr1), 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
